// File: rtl/msg_tag_compare.sv
// ---------------------------------------------------------------------------
// msg_tag_compare
//
// Streaming, constant-time multi-word comparator. A transaction consumes
// exactly NWORDS words of WIDTH bits. In mode 0 every word must be zero. In
// mode 1 every word must equal the matching in_exp word. There is no early
// exit on a mismatch. A registered verdict and a count of failing words are
// then offered on an output valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         begin a transaction (honoured in IDLE only)
//   mode          0 = zero check, 1 = compare to in_exp (latched on start)
//   in_val/in_rdy input word handshake (in_rdy is high only in SCAN)
//   in_msg        message word
//   in_exp        expected tag word (used only when the latched mode is 1)
//   out_val       result valid (high in DONE)
//   out_rdy       consumer accepts the result
//   out_match     1 when all NWORDS words passed
//   out_mism_cnt  number of failing words
//   busy          high in SCAN or DONE
// ---------------------------------------------------------------------------
module msg_tag_compare #(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 4,
    parameter int CNT_W  = $clog2(NWORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_msg,
    input  logic [WIDTH-1:0] in_exp,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_match,
    output logic [CNT_W-1:0] out_mism_cnt,
    output logic             busy
);

    // The word index needs at least one bit, even when NWORDS is 1.
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               mode_q;

    logic               accept;
    logic               last_word;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;

    // Per-word difference and the running accumulator/count values that this
    // word would produce. These are computed for every word, so the timing
    // never depends on the data.
    always_comb begin
        diff      = mode_q ? (in_msg ^ in_exp) : in_msg;
        acc_next  = acc | diff;
        cnt_next  = (|diff) ? cnt + CNT_W'(1) : cnt;
        accept    = (state == SCAN) && in_val;
        last_word = (idx == LAST_IDX);
    end

    // Next-state logic. start is only looked at in IDLE. The final accepted
    // word moves to DONE. The result handshake returns the FSM to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: if (accept && last_word) state_next = DONE;
            DONE: if (out_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded straight from the state register. Because
    // of this, out_val is glitch-free and stays stable throughout DONE.
    always_comb begin
        in_rdy  = (state == SCAN);
        out_val = (state == DONE);
        busy    = (state != IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath registers. The verdict registers are loaded on the last
    // accepted word, so they are already valid when DONE is entered. After
    // that they hold their value through IDLE until the next result is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            acc          <= '0;
            cnt          <= '0;
            mode_q       <= 1'b0;
            out_match    <= 1'b0;
            out_mism_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        idx    <= '0;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        idx <= idx + IDX_W'(1);
                        if (last_word) begin
                            out_match    <= (acc_next == '0);
                            out_mism_cnt <= cnt_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_tag_compare.sv
// ---------------------------------------------------------------------------
// tb_msg_tag_compare
//
// Directed, self-checking bench for msg_tag_compare. The main instance uses
// the default parameters (WIDTH=32, NWORDS=4). Two more instances cover the
// WIDTH=16/NWORDS=1 and WIDTH=8/NWORDS=7 corners. For the main instance,
// expected results are computed from the stimulus word tables and pushed to
// a scoreboard queue. Each entry is popped when out_val appears.
// ---------------------------------------------------------------------------
module tb_msg_tag_compare;

    logic        clk = 1'b0;
    logic        reset;

    // Main instance signals
    logic        start, mode, in_val, in_rdy, out_val, out_rdy, out_match, busy;
    logic [31:0] in_msg, in_exp;
    logic [2:0]  out_mism_cnt;

    // WIDTH=16, NWORDS=1 instance signals
    logic        a_start, a_mode, a_val, a_rdy, a_out_val, a_out_rdy, a_match, a_busy;
    logic [15:0] a_msg, a_exp;
    logic [0:0]  a_cnt;

    // WIDTH=8, NWORDS=7 instance signals
    logic        b_start, b_mode, b_val, b_rdy, b_out_val, b_out_rdy, b_match, b_busy;
    logic [7:0]  b_msg, b_exp;
    logic [2:0]  b_cnt;

    typedef struct packed {
        logic       m;
        logic [7:0] c;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] w_msg [4];
    logic [31:0] w_exp [4];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          start_cyc;
    logic        cur_m;
    logic [7:0]  cur_c;

    always #5 clk = ~clk;

    msg_tag_compare dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_exp(in_exp),
        .out_val(out_val), .out_rdy(out_rdy), .out_match(out_match),
        .out_mism_cnt(out_mism_cnt), .busy(busy)
    );

    msg_tag_compare #(.WIDTH(16), .NWORDS(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .mode(a_mode),
        .in_val(a_val), .in_rdy(a_rdy), .in_msg(a_msg), .in_exp(a_exp),
        .out_val(a_out_val), .out_rdy(a_out_rdy), .out_match(a_match),
        .out_mism_cnt(a_cnt), .busy(a_busy)
    );

    msg_tag_compare #(.WIDTH(8), .NWORDS(7)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .mode(b_mode),
        .in_val(b_val), .in_rdy(b_rdy), .in_msg(b_msg), .in_exp(b_exp),
        .out_val(b_out_val), .out_rdy(b_out_rdy), .out_match(b_match),
        .out_mism_cnt(b_cnt), .busy(b_busy)
    );

    // Advance to 1 time unit after the next rising edge. All driving and
    // sampling happens at that point.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: compute the verdict from the word tables and the mode
    // that will be latched, then queue it.
    task automatic pushExpected(input logic md);
        logic [31:0] d;
        int          c;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            d = md ? (w_msg[i] ^ w_exp[i]) : w_msg[i];
            if (d != 32'd0) c++;
        end
        sb.push_back('{m: (c == 0), c: 8'(c)});
    endtask

    task automatic doStart(input logic md);
        start_cyc = cyc;
        start = 1'b1;
        mode  = md;
        tick();
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int i, input int gap);
        in_val = 1'b0;
        repeat (gap) tick();
        in_msg = w_msg[i];
        in_exp = w_exp[i];
        in_val = 1'b1;
        tick();
        in_val = 1'b0;
    endtask

    // Wait, with a bound, for out_val. Then compare the result against the
    // oldest scoreboard entry.
    task automatic waitResult(input string tag);
        int n;
        exp_t e;
        n = 0;
        while (!out_val && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, "_outval"}, 32'(out_val), 32'd1);
        if (sb.size() == 0) begin
            checkOutput({tag, "_sbempty"}, 32'd0, 32'd1);
            cur_m = 1'b0;
            cur_c = 8'd0;
        end else begin
            e = sb.pop_front();
            cur_m = e.m;
            cur_c = e.c;
            checkOutput({tag, "_match"}, 32'(out_match), 32'(cur_m));
            checkOutput({tag, "_cnt"}, 32'(out_mism_cnt), 32'(cur_c));
        end
    endtask

    task automatic acceptResult(input string tag);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        checkOutput({tag, "_outval_drop"}, 32'(out_val), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 0; mode = 0; in_val = 0; out_rdy = 0; in_msg = '0; in_exp = '0;
        a_start = 0; a_mode = 0; a_val = 0; a_out_rdy = 0; a_msg = '0; a_exp = '0;
        b_start = 0; b_mode = 0; b_val = 0; b_out_rdy = 0; b_msg = '0; b_exp = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_inrdy", 32'(in_rdy), 32'd0);
        checkOutput("rst_outval", 32'(out_val), 32'd0);
        checkOutput("rst_match", 32'(out_match), 32'd0);
        checkOutput("rst_cnt", 32'(out_mism_cnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Zero mode, all zero words, back to back
        w_msg = '{32'h0, 32'h0, 32'h0, 32'h0};
        w_exp = '{32'h0, 32'h0, 32'h0, 32'h0};
        pushExpected(1'b0);
        doStart(1'b0);
        checkOutput("zero_busy", 32'(busy), 32'd1);
        checkOutput("zero_inrdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(i, 0);
        checkOutput("zero_latency", 32'(cyc - start_cyc), 32'd5);
        waitResult("zero");
        acceptResult("zero");

        // Tag mode, one mismatching word, same latency as the matching case
        w_exp = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        w_msg = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEE, 32'hCAFEF00D};
        pushExpected(1'b1);
        doStart(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(i, 0);
        checkOutput("tag1_latency", 32'(cyc - start_cyc), 32'd5);
        waitResult("tag1");
        acceptResult("tag1");

        // Tag mode, full match
        w_msg = w_exp;
        pushExpected(1'b1);
        doStart(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(i, 0);
        checkOutput("tagok_latency", 32'(cyc - start_cyc), 32'd5);
        waitResult("tagok");
        acceptResult("tagok");

        // Input gaps, then back-pressure in DONE with in_val and start toggling
        w_msg = '{32'h0, 32'h0, 32'h3, 32'h0};
        pushExpected(1'b0);
        doStart(1'b0);
        applyStimulus(0, 0);
        in_val = 1'b0;
        tick();
        checkOutput("gap_inrdy", 32'(in_rdy), 32'd1);
        checkOutput("gap_outval", 32'(out_val), 32'd0);
        for (int i = 1; i < 4; i++) applyStimulus(i, 3);
        waitResult("stall");
        for (int k = 0; k < 5; k++) begin
            in_val = 1'b1;
            in_msg = 32'hFFFFFFFF;
            start  = 1'b1;
            tick();
            checkOutput("stall_outval", 32'(out_val), 32'd1);
            checkOutput("stall_match", 32'(out_match), 32'(cur_m));
            checkOutput("stall_cnt", 32'(out_mism_cnt), 32'(cur_c));
        end
        in_val = 1'b0;
        // start together with out_rdy must not restart
        acceptResult("stall");
        start = 1'b0;
        tick();
        checkOutput("stall_norestart", 32'(busy), 32'd0);

        // in_val together with start in IDLE is not consumed, start during
        // SCAN is ignored, and toggling mode mid-SCAN has no effect
        w_exp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        w_msg = w_exp;
        pushExpected(1'b1);
        in_val = 1'b1;
        in_msg = 32'h00000BAD;
        in_exp = 32'h0;
        doStart(1'b1);
        in_val = 1'b0;
        applyStimulus(0, 0);
        mode  = 1'b0;
        start = 1'b1;
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        checkOutput("ign_outval_early", 32'(out_val), 32'd0);
        applyStimulus(3, 0);
        start = 1'b0;
        waitResult("ignore");
        acceptResult("ignore");

        // Reset after 2 of 4 words
        doStart(1'b0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_inrdy", 32'(in_rdy), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_outval", 32'(out_val), 32'd0);
        checkOutput("midrst_match", 32'(out_match), 32'd0);
        w_msg = '{32'h0, 32'h5, 32'h0, 32'h7};
        pushExpected(1'b0);
        doStart(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(i, 0);
        waitResult("postrst");
        acceptResult("postrst");
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        // WIDTH=16, NWORDS=1: a single word goes straight to DONE
        a_start = 1'b1;
        a_mode  = 1'b0;
        tick();
        a_start = 1'b0;
        a_val   = 1'b1;
        a_msg   = 16'h0000;
        tick();
        a_val   = 1'b0;
        checkOutput("w16_outval", 32'(a_out_val), 32'd1);
        checkOutput("w16_match", 32'(a_match), 32'd1);
        checkOutput("w16_cnt", 32'(a_cnt), 32'd0);
        a_out_rdy = 1'b1;
        tick();
        a_out_rdy = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_val   = 1'b1;
        a_msg   = 16'h8000;
        tick();
        a_val   = 1'b0;
        checkOutput("w16_fail_match", 32'(a_match), 32'd0);
        checkOutput("w16_fail_cnt", 32'(a_cnt), 32'd1);

        // WIDTH=8, NWORDS=7: every word fails, the count reaches 7
        b_start = 1'b1;
        b_mode  = 1'b1;
        b_exp   = 8'h00;
        tick();
        b_start = 1'b0;
        b_val   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_msg = 8'(i + 1);
            tick();
        end
        b_val = 1'b0;
        checkOutput("w8_outval", 32'(b_out_val), 32'd1);
        checkOutput("w8_match", 32'(b_match), 32'd0);
        checkOutput("w8_cnt", 32'(b_cnt), 32'd7);
        b_out_rdy = 1'b1;
        tick();
        b_out_rdy = 1'b0;
        checkOutput("w8_idle", 32'(b_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_tag_compare.md
Name: msg_tag_compare

Overview:
- Streaming, parametrised multi-word comparator for the Cryptochip datapath. Generalises the single-word combinational zero compare.
- Consumes a message of NWORDS words of WIDTH bits over a valid/ready interface. Mode 0 checks that every word is zero; mode 1 checks that every word equals an expected tag word.
- Constant-time: every transaction consumes all NWORDS words with no early exit. A single registered verdict and a mismatch count are then presented on an output handshake.

Parameters:
- WIDTH, 32, bits per message word (>=1).
- NWORDS, 4, words per transaction (>=1).
- CNT_W, $clog2(NWORDS+1), width of mismatch counter (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin transaction; sampled only in IDLE.
- mode  input  1  0 = zero check, 1 = compare against in_exp; latched on accepted start.
- in_val  input  1  input word valid.
- in_rdy  output  1  block ready for a word.
- in_msg  input  WIDTH  message word.
- in_exp  input  WIDTH  expected tag word; used only when latched mode=1.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts result.
- out_match  output  1  1 = all NWORDS words passed.
- out_mism_cnt  output  CNT_W  number of failing words.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- States: IDLE, SCAN, DONE.
- Reset (any state, mid-transaction included), effective next edge:
  - state=IDLE, word index=0, accumulator=0, count=0, mode_q=0.
  - in_rdy=0, out_val=0, out_match=0, out_mism_cnt=0, busy=0.
  - Reset dominates all other inputs that cycle.
- IDLE:
  - in_rdy=0, out_val=0.
  - start=1: latch mode into mode_q, clear index, accumulator and count, go to SCAN.
  - in_val in IDLE is never accepted, including the same cycle as start.
- SCAN:
  - in_rdy=1 combinationally.
  - A word is accepted when in_val & in_rdy.
  - Per accepted word: d = mode_q ? (in_msg ^ in_exp) : in_msg. Then acc |= d; if d!=0, count += 1.
  - Index increments per accepted word.
  - The accept with index==NWORDS-1 moves to DONE next edge with acc/count final. No early exit on mismatch.
  - in_val=0 stalls indefinitely; state is held.
  - start is ignored.
- DONE:
  - out_val=1, out_match=(acc==0), out_mism_cnt=count. All are registered and stable until accepted.
  - in_rdy=0.
  - out_rdy=1 returns to IDLE next edge; out_val drops that edge.
  - start in DONE is ignored, including the same cycle as out_rdy. A new start is honoured at the earliest in IDLE, one cycle later.
- Output hold: out_match and out_mism_cnt hold their last value in IDLE until the next start, then read 0/1 per cleared acc only as internal state. Outputs are qualified by out_val only.
- Latency: first word is acceptable the cycle after start. With in_val held high, out_val rises NWORDS+1 cycles after start and is independent of data.
- Widths and limits:
  - count saturates naturally at NWORDS, which fits CNT_W.
  - Index wraps only via the clear on start.
  - NWORDS=1: the single accepted word goes straight to DONE.
- mode_q is unchanged by mode toggling after start.

Test Plan:
- Zero mode, all-zero: start mode=0; 4 words of 0x00000000 back-to-back -> out_val at cycle 5 after start, out_match=1, out_mism_cnt=0.
- Tag mode, one mismatch: mode=1; in_exp = {0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0xCAFEF00D}; in_msg equal except word 2 = 0x89ABCDEE -> out_match=0, out_mism_cnt=1. Timing is identical to the matching case (constant time).
- Stalls and backpressure: in_val gaps of 3 cycles between words; out_rdy held low 5 cycles in DONE -> no extra word accepted; out_val, out_match, out_mism_cnt stable across the stall; IDLE one cycle after out_rdy.
- Ignored inputs: in_val=1 with start in IDLE -> word not consumed. start pulsed during SCAN and DONE -> no restart. Mode toggled mid-SCAN -> result uses the latched mode.
- Reset mid-operation: reset after 2 of 4 words -> next cycle in_rdy=0, busy=0, out_val=0. A following full transaction of mode=0 with words {0, 5, 0, 7} -> out_mism_cnt=2, out_match=0.
- Parameter sweep: WIDTH=16, NWORDS=1 with in_msg=0x0000 -> match=1; WIDTH=8, NWORDS=7 with all words failing -> out_mism_cnt=7, CNT_W=3.
